// File: rtl/reduce_distribute_if.sv
// Handshake bundle for reduce_distribute: total input stream and frame-word output stream.
// out_last exists only when REDUCE_DIST_LAST_EN is defined.
interface reduce_distribute_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef REDUCE_DIST_LAST_EN
  logic         out_last;
`endif

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
`ifdef REDUCE_DIST_LAST_EN
    , input out_last
`endif
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
`ifdef REDUCE_DIST_LAST_EN
    , output out_last
`endif
  );
endinterface

// File: rtl/reduce_distribute.sv
// Expands one W-bit total into a frame of 2^LOG2_LEN words summing to that total.
// Optional REDUCE_DIST_LAST_EN adds out_last on the final beat of each frame.
module reduce_distribute #(
  parameter int LOG2_LEN = 10,
  parameter int W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  reduce_distribute_if.slave bus
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [LOG2_LEN:0] LAST_IDX = {1'b0, {LOG2_LEN{1'b1}}};

  state_t              state;
  state_t              state_next;
  logic [W-1:0]        q;
  logic [LOG2_LEN-1:0] rem;
  // One bit wider than the frame index so the idx < rem compare never wraps.
  logic [LOG2_LEN:0]   idx;
  logic                accept;
  logic                advance;
  logic                bump;
  logic                last_beat;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign advance   = (state == EMIT) && bus.out_ready;
  assign last_beat = (idx == LAST_IDX);
  assign bump      = (idx < {1'b0, rem});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.in_valid)          state_next = EMIT;
      EMIT: if (advance && last_beat)  state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // Quotient/remainder are plain registers, cleared on reset so a restarted
  // block never replays a stale frame value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      rem <= '0;
      idx <= '0;
    end else if (accept) begin
      q   <= bus.in_data >> LOG2_LEN;
      rem <= bus.in_data[LOG2_LEN-1:0];
      idx <= '0;
    end else if (advance) begin
      idx <= idx + 1'b1;
    end
  end

  // Outputs decode only registered state; q + 1 fits in W bits by construction.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == EMIT);
  assign bus.busy      = (state == EMIT);
  assign bus.out_data  = (state == EMIT) ? (q + {{(W-1){1'b0}}, bump}) : '0;

`ifdef REDUCE_DIST_LAST_EN
  assign bus.out_last  = (state == EMIT) && last_beat;
`endif

endmodule

// File: doc/reduce_distribute.md
# reduce_distribute

Inverse of the accumulator stage in the reduction datapath. Accepts one 32-bit total on an input handshake and emits a frame of 2^LOG2_LEN words whose sum is exactly that total. Each word is the quotient of the total divided by the frame length, and the remainder is spread one unit at a time over the leading words. It sits upstream of the frame accumulator as its stimulus/expansion source. A frame produced here and fed back into the accumulator returns the original total.

## Interface

Parameters:
- `LOG2_LEN`, default 10: log2 of the frame length. Frame length is 1024 words. Legal range is 1..16.
- `W`, default 32: width of the data path.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_data`, input, W: total to distribute.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a total.
- `out_data`, output, W: current frame word.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream accepts the word. Tie high when driving a sink that has no ready.
- `busy`, output, 1: a frame is in progress.
- `out_last`, output, 1: only present with `REDUCE_DIST_LAST_EN`; see Configuration.

## Operation

- Two states: IDLE and EMIT.
- **IDLE**
  - `in_ready` = 1, `out_valid` = 0, `busy` = 0.
  - When `in_valid` && `in_ready`, register:
    - `q` = `in_data >> LOG2_LEN`
    - `rem` = `in_data[LOG2_LEN-1:0]`
    - `idx` = 0
  - Then go to EMIT.
- **EMIT**
  - `in_ready` = 0; `in_valid` is ignored.
  - `out_valid` = 1, `busy` = 1.
  - `out_data` = `q + (idx < rem ? 1 : 0)`, computed in W bits. It cannot overflow, because `q + 1 <= 2^(W-LOG2_LEN)`.
  - On `out_valid` && `out_ready`, `idx` increments.
  - When the beat with `idx == 2^LOG2_LEN - 1` is accepted, go to IDLE.
- **Width rules**
  - `idx` is LOG2_LEN+1 bits wide internally so the compare never wraps.
  - `rem` is LOG2_LEN bits wide.
- **Invariant:** the sum of all frame words modulo 2^W equals the accepted `in_data`.
- **Backpressure:** while `out_valid` = 1 and `out_ready` = 0, `out_data` and `idx` hold stable.
- **Reset:** `rst` in any state, including mid-frame, forces IDLE on the next edge. It also clears `idx`, `q` and `rem` to 0. The partial frame is abandoned and no further words are emitted.

## Timing

Reset values:
- `in_ready` = 1
- `out_valid` = 0
- `out_data` = 0
- `busy` = 0
- `out_last` = 0

Cycle behaviour:
- **Latency:** a total accepted at edge t makes the first word valid in the cycle after edge t (out_valid high from t+1).
- **Throughput:** one word per cycle with `out_ready` held high. A full frame occupies 2^LOG2_LEN cycles.
- **Frame spacing:** after the last beat is accepted at edge e, `in_ready` = 1 in the cycle after e.
  - A new total can be accepted at edge e+1.
  - Its first word appears after e+1.
  - The minimum gap between frames is therefore one idle cycle.
- **Outputs:** all outputs are registered or decoded only from registered state. None has a combinational path from `in_valid`/`in_data` or from `out_ready`.

## Configuration

- **`REDUCE_DIST_LAST_EN` defined:**
  - Adds the output port `out_last`.
  - `out_last` = 1 exactly when `out_valid` && `idx == 2^LOG2_LEN - 1`.
  - Like `out_data`, it holds under backpressure.
- **Not defined:** the port is absent and behaviour is otherwise identical.

## Test plan

- **Remainder spread:** `in_data` = 5123 (1024·5 + 3), `out_ready` = 1 → 3 words of 6 then 1021 words of 5. `in_ready` returns to 1 one cycle after the last beat.
- **Zero and maximum totals:**
  - `in_data` = 0 → 1024 words of 0.
  - `in_data` = 0xFFFFFFFF → 1023 words of 0x00400000 then one word of 0x003FFFFF.
- **Backpressure:** `in_data` = 1000, with `out_ready` driven in a pseudo-random pattern → each word is 0 or 1, exactly 1000 ones arrive first, and `out_data` is stable whenever `out_ready` = 0.
- **Mid-frame reset and blocked input:**
  - Assert `rst` for one cycle after 300 beats → `out_valid` = 0 and `in_ready` = 1 the next cycle, and no further words are emitted.
  - `in_valid` held high throughout is not accepted during EMIT.
- **Loopback:**
  - Feed the output into the frame accumulator with `out_ready` = 1, for the totals 7, 123456789 and 0x80000001 in back-to-back frames → the accumulator reports exactly each total, in order.
  - With `REDUCE_DIST_LAST_EN` defined, `out_last` pulses once per frame, on beat 1023.
